candle_array_ctrl: RTL and testbench

//  Parametrised successor of the 8-candle set/clear controller: N candle flags,

---
 rtl/candle_pkg.sv | 50 +++++
 rtl/candle_burn_timer.sv | 40 ++++
 rtl/candle_array_ctrl.sv | 112 +++++++++++
 tb/tb_candle_array_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/candle_pkg.sv
// Shared defaults, per-candle action encoding and elaboration helpers for the
// candle array controller.
`ifndef CANDLE_PKG_SV
`define CANDLE_PKG_SV

// True when a cntw-bit down-counter can hold burn-1.
`define CANDLE_CNT_W_OK(burn, cntw) ((64'd1 << (cntw)) >= 64'(burn))

package candle_pkg;

   localparam int CANDLE_DEF_N    = 8;
   localparam int CANDLE_DEF_BURN = 1000;

   typedef enum logic [2:0] {
      ACT_HOLD,
      ACT_BLOW,
      ACT_CLEAR,
      ACT_SET,
      ACT_EXPIRE
   } candle_act_e;

   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((64'd1 << result) < 64'(value)) begin
         result = result + 1;
      end
      return result;
   endfunction

   // Resolves competing requests for one candle, highest priority first.
   function automatic candle_act_e candle_next_act(input logic blow,
                                                   input logic clr_hit,
                                                   input logic set_hit,
                                                   input logic expired);
      if (blow) begin
         return ACT_BLOW;
      end else if (clr_hit) begin
         return ACT_CLEAR;
      end else if (set_hit) begin
         return ACT_SET;
      end else if (expired) begin
         return ACT_EXPIRE;
      end
      return ACT_HOLD;
   endfunction

endpackage

`endif

// File: rtl/candle_burn_timer.sv
// Per-candle burn down-counter: loads on light, counts while lit and flags
// expiry when it reaches zero while still running.
module candle_burn_timer #(
   parameter int BURN_CYCLES = 1000,
   parameter int CNT_W       = 10
) (
   input  logic sys_clk,
   input  logic clr_async,
   input  logic load,
   input  logic run,
   input  logic kill,
   output logic expired
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign expired = run && (cnt_q == '0);

   // The counter parks at zero once expired; the owner drops 'run' next cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (kill) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = CNT_W'(BURN_CYCLES - 1);
      end else if (run && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge sys_clk or posedge clr_async) begin
      if (clr_async) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/candle_array_ctrl.sv
// N-channel candle set/clear controller with optional per-candle burn timers,
// global extinguish and combinational lit-count status.
module candle_array_ctrl
   import candle_pkg::*;
#(
   parameter int NUM_CANDLES = CANDLE_DEF_N,
   parameter int POS_W       = 3,
   parameter bit AUTO_BURN   = 1'b1,
   parameter int BURN_CYCLES = CANDLE_DEF_BURN,
   parameter int CNT_W       = 10
) (
   input  logic                   sys_clk,
   input  logic                   clr_async,
   input  logic [POS_W-1:0]       pos_to_set,
   input  logic                   set_enable,
   input  logic [POS_W-1:0]       pos_to_clear,
   input  logic                   clear_enable,
   input  logic                   blow_all,
   output logic [NUM_CANDLES-1:0] candle_state,
   output logic [NUM_CANDLES-1:0] burnout,
   output logic [POS_W:0]         lit_count,
   output logic                   all_lit,
   output logic                   any_lit
);

   localparam int LC_W = POS_W + 1;

   if ((POS_W < clog2(NUM_CANDLES)) || !(`CANDLE_CNT_W_OK(BURN_CYCLES, CNT_W))) begin : g_param_err
      $error("candle_array_ctrl: POS_W or CNT_W too narrow for NUM_CANDLES/BURN_CYCLES");
   end

   logic [NUM_CANDLES-1:0] state_q, state_d;
   logic [NUM_CANDLES-1:0] burnout_q, burnout_d;
   logic [NUM_CANDLES-1:0] set_hit, clr_hit;
   logic [NUM_CANDLES-1:0] expired, timer_load, timer_kill;

   // Out-of-range positions simply match no channel and are dropped here.
   always_comb begin
      set_hit = '0;
      clr_hit = '0;
      for (int i = 0; i < NUM_CANDLES; i++) begin
         set_hit[i] = set_enable   && (pos_to_set   == POS_W'(i));
         clr_hit[i] = clear_enable && (pos_to_clear == POS_W'(i));
      end
   end

   always_comb begin
      state_d    = state_q;
      burnout_d  = '0;
      timer_load = '0;
      timer_kill = '0;
      for (int i = 0; i < NUM_CANDLES; i++) begin
         case (candle_next_act(blow_all, clr_hit[i], set_hit[i], expired[i]))
            ACT_BLOW, ACT_CLEAR: begin
               state_d[i]    = 1'b0;
               timer_kill[i] = 1'b1;
            end
            ACT_SET: begin
               state_d[i]    = 1'b1;
               timer_load[i] = AUTO_BURN;
            end
            ACT_EXPIRE: begin
               state_d[i]   = 1'b0;
               burnout_d[i] = 1'b1;
            end
            default: begin
               state_d[i] = state_q[i];
            end
         endcase
         if (!AUTO_BURN) begin
            timer_kill[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_CANDLES; g++) begin : g_timer
      candle_burn_timer #(
         .BURN_CYCLES (BURN_CYCLES),
         .CNT_W       (CNT_W)
      ) u_timer (
         .sys_clk   (sys_clk),
         .clr_async (clr_async),
         .load      (timer_load[g]),
         .run       (AUTO_BURN && state_q[g]),
         .kill      (timer_kill[g]),
         .expired   (expired[g])
      );
   end

   always_ff @(posedge sys_clk or posedge clr_async) begin
      if (clr_async) begin
         state_q   <= '0;
         burnout_q <= '0;
      end else begin
         state_q   <= state_d;
         burnout_q <= burnout_d;
      end
   end

   always_comb begin
      lit_count = '0;
      for (int i = 0; i < NUM_CANDLES; i++) begin
         lit_count = lit_count + LC_W'(state_q[i]);
      end
   end

   assign candle_state = state_q;
   assign burnout      = burnout_q;
   assign all_lit      = &state_q;
   assign any_lit      = |state_q;

endmodule

// File: tb/tb_candle_array_ctrl.sv
// Self-checking bench: three controller instances (timed 8-candle, untimed
// 6-candle, long-burn 8-candle) on shared inputs against a lifetime model.
module tb_candle_array_ctrl;

   localparam int NI = 3;

   logic       sys_clk;
   logic       clr_async;
   logic [2:0] pos_to_set;
   logic       set_enable;
   logic [2:0] pos_to_clear;
   logic       clear_enable;
   logic       blow_all;

   logic [7:0] a_state, a_bo;
   logic [3:0] a_cnt;
   logic       a_all, a_any;
   logic [5:0] b_state, b_bo;
   logic [3:0] b_cnt;
   logic       b_all, b_any;
   logic [7:0] c_state, c_bo;
   logic [3:0] c_cnt;
   logic       c_all, c_any;

   int n_vec  = 0;
   int n_miss = 0;

   candle_array_ctrl #(
      .NUM_CANDLES(8), .POS_W(3), .AUTO_BURN(1'b1), .BURN_CYCLES(5), .CNT_W(3)
   ) dut_a (
      .sys_clk(sys_clk), .clr_async(clr_async),
      .pos_to_set(pos_to_set), .set_enable(set_enable),
      .pos_to_clear(pos_to_clear), .clear_enable(clear_enable),
      .blow_all(blow_all),
      .candle_state(a_state), .burnout(a_bo), .lit_count(a_cnt),
      .all_lit(a_all), .any_lit(a_any)
   );

   candle_array_ctrl #(
      .NUM_CANDLES(6), .POS_W(3), .AUTO_BURN(1'b0), .BURN_CYCLES(5), .CNT_W(3)
   ) dut_b (
      .sys_clk(sys_clk), .clr_async(clr_async),
      .pos_to_set(pos_to_set), .set_enable(set_enable),
      .pos_to_clear(pos_to_clear), .clear_enable(clear_enable),
      .blow_all(blow_all),
      .candle_state(b_state), .burnout(b_bo), .lit_count(b_cnt),
      .all_lit(b_all), .any_lit(b_any)
   );

   candle_array_ctrl #(
      .NUM_CANDLES(8), .POS_W(3), .AUTO_BURN(1'b1), .BURN_CYCLES(20), .CNT_W(5)
   ) dut_c (
      .sys_clk(sys_clk), .clr_async(clr_async),
      .pos_to_set(pos_to_set), .set_enable(set_enable),
      .pos_to_clear(pos_to_clear), .clear_enable(clear_enable),
      .blow_all(blow_all),
      .candle_state(c_state), .burnout(c_bo), .lit_count(c_cnt),
      .all_lit(c_all), .any_lit(c_any)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   function automatic int inst_n(input int k);
      return (k == 1) ? 6 : 8;
   endfunction

   function automatic bit inst_auto(input int k);
      return (k != 1);
   endfunction

   function automatic int inst_burn(input int k);
      return (k == 2) ? 20 : 5;
   endfunction

   // Model: each lit candle carries the number of edges it has left to live.
   bit m_lit [NI][64];
   int m_rem [NI][64];
   bit m_bo  [NI][64];

   task automatic model_reset();
      for (int k = 0; k < NI; k++) begin
         for (int i = 0; i < 64; i++) begin
            m_lit[k][i] = 1'b0;
            m_rem[k][i] = 0;
            m_bo[k][i]  = 1'b0;
         end
      end
   endtask

   task automatic model_step(input int k);
      for (int i = 0; i < inst_n(k); i++) begin
         m_bo[k][i] = 1'b0;
         if (blow_all) begin
            m_lit[k][i] = 1'b0;
            m_rem[k][i] = 0;
         end else if (clear_enable && (int'(pos_to_clear) == i)) begin
            m_lit[k][i] = 1'b0;
            m_rem[k][i] = 0;
         end else if (set_enable && (int'(pos_to_set) == i)) begin
            m_lit[k][i] = 1'b1;
            m_rem[k][i] = inst_auto(k) ? inst_burn(k) : 0;
         end else if (m_lit[k][i] && inst_auto(k)) begin
            m_rem[k][i] = m_rem[k][i] - 1;
            if (m_rem[k][i] == 0) begin
               m_lit[k][i] = 1'b0;
               m_bo[k][i]  = 1'b1;
            end
         end
      end
   endtask

   always @(posedge sys_clk or posedge clr_async) begin
      if (clr_async) begin
         model_reset();
      end else begin
         for (int k = 0; k < NI; k++) begin
            model_step(k);
         end
      end
   end

   function automatic logic [63:0] model_vec(input int k, input bit want_bo);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < inst_n(k); i++) begin
         v[i] = want_bo ? m_bo[k][i] : m_lit[k][i];
      end
      return v;
   endfunction

   function automatic int model_count(input int k);
      int c;
      c = 0;
      for (int i = 0; i < inst_n(k); i++) begin
         c = c + int'(m_lit[k][i]);
      end
      return c;
   endfunction

   task automatic check_output(input string name, input int k,
                               input logic [63:0] act, input logic [63:0] exp);
      n_vec = n_vec + 1;
      if (act !== exp) begin
         n_miss = n_miss + 1;
         $display("[TB] FAIL %s inst%0d: got %0h, want %0h (t=%0t)", name, k, act, exp, $time);
      end
   endtask

   task automatic compare_inst(input int k, input logic [63:0] st, input logic [63:0] bo,
                               input logic [63:0] cnt, input logic al, input logic an);
      int ec;
      ec = model_count(k);
      check_output("state", k, st, model_vec(k, 1'b0));
      check_output("burnout", k, bo, model_vec(k, 1'b1));
      check_output("lit_count", k, cnt, 64'(ec));
      check_output("all_lit", k, 64'(al), 64'(ec == inst_n(k)));
      check_output("any_lit", k, 64'(an), 64'(ec != 0));
   endtask

   always @(negedge sys_clk) begin
      compare_inst(0, 64'(a_state), 64'(a_bo), 64'(a_cnt), a_all, a_any);
      compare_inst(1, 64'(b_state), 64'(b_bo), 64'(b_cnt), b_all, b_any);
      compare_inst(2, 64'(c_state), 64'(c_bo), 64'(c_cnt), c_all, c_any);
   end

   task automatic tick();
      @(posedge sys_clk);
      #2;
   endtask

   // Drive one edge's worth of requests, take the edge, then return to idle.
   task automatic apply_stimulus(input bit s_en, input int s_pos,
                                 input bit c_en, input int c_pos, input bit blow);
      set_enable   = s_en;
      pos_to_set   = 3'(s_pos);
      clear_enable = c_en;
      pos_to_clear = 3'(c_pos);
      blow_all     = blow;
      tick();
      set_enable   = 1'b0;
      clear_enable = 1'b0;
      blow_all     = 1'b0;
   endtask

   initial begin
      clr_async    = 1'b1;
      set_enable   = 1'b0;
      clear_enable = 1'b0;
      blow_all     = 1'b0;
      pos_to_set   = 3'd0;
      pos_to_clear = 3'd0;
      tick();
      tick();
      check_output("reset_state", 0, 64'(a_state), 64'h0);
      check_output("reset_count", 0, 64'(a_cnt), 64'h0);
      clr_async = 1'b0;

      // Reset mid-operation
      apply_stimulus(1, 0, 0, 0, 0);
      apply_stimulus(1, 3, 0, 0, 0);
      apply_stimulus(1, 7, 0, 0, 0);
      check_output("t1_lit", 0, 64'(a_state), 64'h89);
      check_output("t1_lit_c", 2, 64'(c_state), 64'h89);
      clr_async = 1'b1;
      #1;
      check_output("t1_async_state", 0, 64'(a_state), 64'h0);
      check_output("t1_async_count", 0, 64'(a_cnt), 64'h0);
      check_output("t1_async_bo", 0, 64'(a_bo), 64'h0);
      check_output("t1_async_state_c", 2, 64'(c_state), 64'h0);
      #1;
      clr_async = 1'b0;

      // Burn-out latency, BURN_CYCLES=5
      apply_stimulus(1, 2, 0, 0, 0);
      check_output("t2_edge0", 0, 64'(a_state), 64'h04);
      for (int e = 1; e <= 4; e++) begin
         tick();
         check_output("t2_still_lit", 0, 64'(a_state), 64'h04);
         check_output("t2_no_bo", 0, 64'(a_bo), 64'h0);
      end
      tick();
      check_output("t2_out", 0, 64'(a_state), 64'h0);
      check_output("t2_bo", 0, 64'(a_bo), 64'h04);
      tick();
      check_output("t2_bo_1cyc", 0, 64'(a_bo), 64'h0);

      // Set and clear collisions
      apply_stimulus(1, 4, 1, 4, 0);
      check_output("t3_unlit", 0, 64'(a_state[4]), 64'h0);
      apply_stimulus(1, 4, 0, 0, 0);
      apply_stimulus(1, 4, 1, 4, 0);
      check_output("t3_lit", 0, 64'(a_state[4]), 64'h0);
      check_output("t3_lit_bo", 0, 64'(a_bo), 64'h0);
      apply_stimulus(1, 5, 1, 2, 0);
      check_output("t3_diff", 0, 64'(a_state), 64'h20);
      check_output("t3_diff_c", 2, 64'(c_state), 64'h20);

      // Relight at edge 3 of 5 extinguishes at edge 8
      apply_stimulus(1, 1, 0, 0, 0);
      tick();
      tick();
      apply_stimulus(1, 1, 0, 0, 0);
      for (int e = 4; e <= 7; e++) begin
         tick();
         check_output("t4_lit", 0, 64'(a_state[1]), 64'h1);
         check_output("t4_no_bo", 0, 64'(a_bo[1]), 64'h0);
      end
      tick();
      check_output("t4_out", 0, 64'(a_state[1]), 64'h0);
      check_output("t4_bo", 0, 64'(a_bo), 64'h02);

      // Set on the expiring edge wins
      apply_stimulus(1, 3, 0, 0, 0);
      repeat (4) tick();
      apply_stimulus(1, 3, 0, 0, 0);
      check_output("t4b_relit", 0, 64'(a_state[3]), 64'h1);
      check_output("t4b_no_bo", 0, 64'(a_bo), 64'h0);
      repeat (4) tick();
      tick();
      check_output("t4b_out", 0, 64'(a_state[3]), 64'h0);
      check_output("t4b_bo", 0, 64'(a_bo), 64'h08);

      // Light all, then blow on the edge candle 3 of dut_a would expire
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1, i, 0, 0, 0);
      end
      check_output("t5_all_c", 2, 64'(c_all), 64'h1);
      check_output("t5_cnt_c", 2, 64'(c_cnt), 64'h8);
      check_output("t5_all_b", 1, 64'(b_all), 64'h1);
      check_output("t5_cnt_b", 1, 64'(b_cnt), 64'h6);
      apply_stimulus(0, 0, 0, 0, 1);
      check_output("t5_blow_c", 2, 64'(c_state), 64'h0);
      check_output("t5_blow_bo_c", 2, 64'(c_bo), 64'h0);
      check_output("t5_blow_a", 0, 64'(a_state), 64'h0);
      check_output("t5_blow_bo_a", 0, 64'(a_bo), 64'h0);
      check_output("t5_blow_b", 1, 64'(b_state), 64'h0);

      // Out-of-range index and untimed hold
      apply_stimulus(1, 6, 0, 0, 0);
      check_output("t6_pos6", 1, 64'(b_state), 64'h0);
      apply_stimulus(1, 7, 0, 0, 0);
      check_output("t6_pos7", 1, 64'(b_state), 64'h0);
      apply_stimulus(1, 5, 0, 0, 0);
      check_output("t6_set5", 1, 64'(b_state), 64'h20);
      repeat (2000) tick();
      check_output("t6_hold", 1, 64'(b_state), 64'h20);
      check_output("t6_hold_any", 1, 64'(b_any), 64'h1);
      check_output("t6_burnt_a", 0, 64'(a_state), 64'h0);
      check_output("t6_burnt_c", 2, 64'(c_state), 64'h0);

      tick();
      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
